// File: rtl/prach_pkg.sv
// Shared PRACH front-end constants and framer state encoding.
package prach_pkg;

    localparam int unsigned NumFftPoints = 1536;
    localparam int unsigned SampleWidth  = 16;
    localparam int unsigned CpLenWidth   = 12;
    localparam int unsigned NumSymWidth  = 4;
    localparam int unsigned SmpCntWidth  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        SYM  = 2'd2
    } framer_state_t;

endpackage

// File: rtl/prach_fft_framer.sv
// Strips the PRACH cyclic prefix and frames each 1536-sample symbol for the FFT.
// Optional abort counter output enabled by PRACH_FRAMER_ABORT_CNT_EN.
module prach_fft_framer
    import prach_pkg::*;
#(
    parameter int unsigned HDR_WIDTH = 120
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SampleWidth-1:0] din_dr,
    input  logic [SampleWidth-1:0] din_di,
    input  logic                   din_dv,
    input  logic                   sync_in,
    input  logic [HDR_WIDTH-1:0]   hdr_in,
    input  logic [CpLenWidth-1:0]  cp_len,
    input  logic [NumSymWidth-1:0] num_sym,
    output logic [SampleWidth-1:0] dout_dr,
    output logic [SampleWidth-1:0] dout_di,
    output logic                   dout_dv,
    output logic                   sync_out,
    output logic [HDR_WIDTH-1:0]   hdr_out,
    output logic [NumSymWidth-1:0] sym_idx,
    output logic                   abort
`ifdef PRACH_FRAMER_ABORT_CNT_EN
    ,
    output logic [15:0]            abort_cnt
`endif
);

    localparam logic [SmpCntWidth-1:0] LastSmp = SmpCntWidth'(NumFftPoints - 1);

    framer_state_t          state;
    logic [CpLenWidth-1:0]  cp_cnt;
    logic [CpLenWidth-1:0]  cp_len_q;
    logic [SmpCntWidth-1:0] smp_cnt;
    logic [NumSymWidth-1:0] sym_cnt;
    logic [NumSymWidth-1:0] num_last;
    logic [HDR_WIDTH-1:0]   hdr_q;

    logic                   start_c;
    logic                   abort_c;
    logic                   fwd_c;
    logic                   first_c;
    logic [NumSymWidth-1:0] idx_c;
    logic [NumSymWidth-1:0] num_last_c;
    logic [HDR_WIDTH-1:0]   hdr_c;

    // A qualified start always wins, including over an occasion in flight.
    always_comb begin
        start_c    = sync_in & din_dv;
        abort_c    = start_c && (state != IDLE);
        fwd_c      = 1'b0;
        first_c    = 1'b0;
        idx_c      = sym_cnt;
        hdr_c      = hdr_q;
        num_last_c = (num_sym == '0) ? '0 : NumSymWidth'(num_sym - 4'd1);
        if (start_c) begin
            idx_c = '0;
            hdr_c = hdr_in;
            if (cp_len == '0) begin
                fwd_c   = 1'b1;
                first_c = 1'b1;
            end
        end else if ((state == SYM) && din_dv) begin
            fwd_c   = 1'b1;
            first_c = (smp_cnt == '0);
        end
    end

    // Occasion FSM and sample/CP/symbol counters; all advance on valid samples only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cp_cnt   <= '0;
            cp_len_q <= '0;
            smp_cnt  <= '0;
            sym_cnt  <= '0;
            num_last <= '0;
            hdr_q    <= '0;
        end else if (start_c) begin
            hdr_q    <= hdr_in;
            cp_len_q <= cp_len;
            num_last <= num_last_c;
            sym_cnt  <= '0;
            cp_cnt   <= '0;
            smp_cnt  <= '0;
            if (cp_len == '0) begin
                state   <= SYM;
                smp_cnt <= SmpCntWidth'(1);
            end else if (cp_len == CpLenWidth'(1)) begin
                state <= SYM;
            end else begin
                state  <= CP;
                cp_cnt <= CpLenWidth'(1);
            end
        end else if (din_dv) begin
            case (state)
                CP: begin
                    if (cp_cnt == CpLenWidth'(cp_len_q - 12'd1)) begin
                        state  <= SYM;
                        cp_cnt <= '0;
                    end else begin
                        cp_cnt <= cp_cnt + CpLenWidth'(1);
                    end
                end
                SYM: begin
                    if (smp_cnt == LastSmp) begin
                        smp_cnt <= '0;
                        if (sym_cnt == num_last) begin
                            state   <= IDLE;
                            sym_cnt <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + NumSymWidth'(1);
                        end
                    end else begin
                        smp_cnt <= smp_cnt + SmpCntWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register: one cycle of latency for every output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_dr  <= '0;
            dout_di  <= '0;
            dout_dv  <= 1'b0;
            sync_out <= 1'b0;
            hdr_out  <= '0;
            sym_idx  <= '0;
            abort    <= 1'b0;
`ifdef PRACH_FRAMER_ABORT_CNT_EN
            abort_cnt <= '0;
`endif
        end else begin
            dout_dv  <= fwd_c;
            sync_out <= first_c;
            abort    <= abort_c;
            if (fwd_c) begin
                dout_dr <= din_dr;
                dout_di <= din_di;
                sym_idx <= idx_c;
            end
            if (first_c) begin
                hdr_out <= hdr_c;
            end
`ifdef PRACH_FRAMER_ABORT_CNT_EN
            if (abort_c && (abort_cnt != 16'hFFFF)) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_prach_fft_framer.sv
// Directed bench for prach_fft_framer; inputs change just after a rising edge,
// outputs are checked 1 time unit after the following edge.
module tb_prach_fft_framer;

    localparam logic [119:0] HDR_A = 120'h0123_4567_89AB_CDEF_0011_2233_4455_66;
    localparam logic [119:0] HDR_B = 120'hFEDC_BA98_7654_3210_A5A5_5A5A_C3C3_3C;
    localparam logic [119:0] HDR_C = 120'h0F0F_F0F0_1234_ABCD_9876_5555_AAAA_77;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  din_dr, din_di;
    logic         din_dv, sync_in;
    logic [119:0] hdr_in;
    logic [11:0]  cp_len;
    logic [3:0]   num_sym;
    logic [15:0]  dout_dr, dout_di;
    logic         dout_dv, sync_out, abort;
    logic [119:0] hdr_out;
    logic [3:0]   sym_idx;
`ifdef PRACH_FRAMER_ABORT_CNT_EN
    logic [15:0]  abort_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    prach_fft_framer #(.HDR_WIDTH(120)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dr   (din_dr),
        .din_di   (din_di),
        .din_dv   (din_dv),
        .sync_in  (sync_in),
        .hdr_in   (hdr_in),
        .cp_len   (cp_len),
        .num_sym  (num_sym),
        .dout_dr  (dout_dr),
        .dout_di  (dout_di),
        .dout_dv  (dout_dv),
        .sync_out (sync_out),
        .hdr_out  (hdr_out),
        .sym_idx  (sym_idx),
        .abort    (abort)
`ifdef PRACH_FRAMER_ABORT_CNT_EN
        ,
        .abort_cnt(abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Present one input cycle, then settle just after the capturing edge.
    task automatic drive(input logic dv, input logic sy, input logic [15:0] i);
        din_dv  = dv;
        sync_in = sy;
        din_dr  = i;
        din_di  = i ^ 16'h5A5A;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'd0);
        drive(1'b0, 1'b0, 16'd0);
        n_checks++;
        if ({dout_dr, dout_di, dout_dv, sync_out, hdr_out, sym_idx, abort} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dv=%b sync=%b abort=%b idx=%0d hdr=%h, want all 0",
                     dout_dv, sync_out, abort, sym_idx, hdr_out);
        end
`ifdef PRACH_FRAMER_ABORT_CNT_EN
        n_checks++;
        if (abort_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_abort_cnt: got %0d want 0", abort_cnt);
        end
`endif
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_basic();
        int n_out = 0;
        int n_sync = 0;
        cp_len = 12'd3072; num_sym = 4'd1; hdr_in = HDR_A;
        for (int n = 0; n < 4612; n++) begin
            logic e_dv;
            e_dv = (n >= 3072) && (n < 4608);
            drive(n < 4608, n == 0, 16'(n));
            if (n == 1) hdr_in = HDR_C;
            n_checks++;
            if (dout_dv !== e_dv || sync_out !== (n == 3072) || abort !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_ctrl n=%0d: got dv=%b sync=%b abort=%b want dv=%b sync=%b abort=0",
                         n, dout_dv, sync_out, abort, e_dv, n == 3072);
            end
            if (e_dv) begin
                n_out++;
                n_checks++;
                if (dout_dr !== 16'(n) || dout_di !== (16'(n) ^ 16'h5A5A) || sym_idx !== 4'd0) begin
                    n_fail++;
                    $display("FAIL basic_data n=%0d: got I=%0d Q=%h idx=%0d want I=%0d Q=%h idx=0",
                             n, dout_dr, dout_di, sym_idx, n, 16'(n) ^ 16'h5A5A);
                end
            end
            if (sync_out === 1'b1) n_sync++;
        end
        n_checks++;
        if (n_out != 1536 || n_sync != 1 || hdr_out !== HDR_A) begin
            n_fail++;
            $display("FAIL basic_totals: got outputs=%0d syncs=%0d hdr=%h want 1536 1 %h",
                     n_out, n_sync, hdr_out, HDR_A);
        end
    endtask

    task automatic test_multi();
        cp_len = 12'd0; num_sym = 4'd3; hdr_in = HDR_B;
        for (int n = 0; n < 4612; n++) begin
            logic       e_dv, e_sync;
            logic [3:0] e_idx;
            e_dv   = n < 4608;
            e_sync = e_dv && (n % 1536 == 0);
            e_idx  = 4'(n / 1536);
            drive(n < 4608, n == 0, 16'(n + 100));
            n_checks++;
            if (dout_dv !== e_dv || sync_out !== e_sync) begin
                n_fail++;
                $display("FAIL multi_ctrl n=%0d: got dv=%b sync=%b want dv=%b sync=%b",
                         n, dout_dv, sync_out, e_dv, e_sync);
            end
            if (e_dv) begin
                n_checks++;
                if (sym_idx !== e_idx || dout_dr !== 16'(n + 100) || hdr_out !== HDR_B) begin
                    n_fail++;
                    $display("FAIL multi_data n=%0d: got idx=%0d I=%0d hdr=%h want idx=%0d I=%0d hdr=%h",
                             n, sym_idx, dout_dr, hdr_out, e_idx, n + 100, HDR_B);
                end
            end
        end
    endtask

    task automatic test_sparse();
        int k = 0;
        cp_len = 12'd10; num_sym = 4'd1; hdr_in = HDR_C;
        for (int c = 0; c < 3100; c++) begin
            logic dv, e_dv;
            dv   = (c % 2 == 0) && (k < 1546);
            e_dv = dv && (k >= 10);
            drive(dv, dv && (k == 0), 16'(k));
            n_checks++;
            if (dout_dv !== e_dv || sync_out !== (e_dv && k == 10)) begin
                n_fail++;
                $display("FAIL sparse_ctrl c=%0d k=%0d: got dv=%b sync=%b want dv=%b sync=%b",
                         c, k, dout_dv, sync_out, e_dv, e_dv && k == 10);
            end
            if (e_dv) begin
                n_checks++;
                if (dout_dr !== 16'(k) || sym_idx !== 4'd0) begin
                    n_fail++;
                    $display("FAIL sparse_data k=%0d: got I=%0d idx=%0d want I=%0d idx=0",
                             k, dout_dr, sym_idx, k);
                end
            end
            if (dv) k++;
        end
    endtask

    task automatic test_restart();
        cp_len = 12'd0; num_sym = 4'd2; hdr_in = HDR_A;
        for (int n = 0; n < 3776; n++) begin
            int         m;
            logic       e_dv, e_sync, e_abort;
            logic [3:0] e_idx;
            m = n - 700;
            if (n < 700) begin
                e_dv = 1'b1; e_sync = (n == 0); e_abort = 1'b0; e_idx = 4'd0;
            end else begin
                e_dv = m < 3072; e_sync = e_dv && (m % 1536 == 0);
                e_abort = (m == 0); e_idx = 4'(m / 1536);
            end
            if (n == 700) hdr_in = HDR_B;
            drive(n < 3772, (n == 0) || (n == 700), 16'(n));
            n_checks++;
            if (dout_dv !== e_dv || sync_out !== e_sync || abort !== e_abort) begin
                n_fail++;
                $display("FAIL restart_ctrl n=%0d: got dv=%b sync=%b abort=%b want dv=%b sync=%b abort=%b",
                         n, dout_dv, sync_out, abort, e_dv, e_sync, e_abort);
            end
            if (e_dv) begin
                n_checks++;
                if (sym_idx !== e_idx || dout_dr !== 16'(n) || hdr_out !== ((n < 700) ? HDR_A : HDR_B)) begin
                    n_fail++;
                    $display("FAIL restart_data n=%0d: got idx=%0d I=%0d hdr=%h want idx=%0d I=%0d",
                             n, sym_idx, dout_dr, hdr_out, e_idx, n);
                end
            end
        end
`ifdef PRACH_FRAMER_ABORT_CNT_EN
        n_checks++;
        if (abort_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL restart_abort_cnt: got %0d want 1", abort_cnt);
        end
`endif
    endtask

    task automatic test_reset_unqual();
        cp_len = 12'd0; num_sym = 4'd1; hdr_in = HDR_C;
        drive(1'b0, 1'b1, 16'd9);
        drive(1'b0, 1'b0, 16'd9);
        n_checks++;
        if (dout_dv !== 1'b0 || sync_out !== 1'b0) begin
            n_fail++;
            $display("FAIL unqualified_start: got dv=%b sync=%b want 0 0", dout_dv, sync_out);
        end
        cp_len = 12'd100;
        for (int n = 0; n < 20; n++) drive(1'b1, n == 0, 16'(n));
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'd20);
        n_checks++;
        if ({dout_dr, dout_di, dout_dv, sync_out, hdr_out, sym_idx, abort} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_cp: got dv=%b sync=%b abort=%b idx=%0d hdr=%h, want all 0",
                     dout_dv, sync_out, abort, sym_idx, hdr_out);
        end
        rst_n = 1'b1;
        cp_len = 12'd5; hdr_in = HDR_A;
        for (int n = 0; n < 1545; n++) begin
            logic e_dv;
            e_dv = (n >= 5) && (n < 1541);
            drive(n < 1541, n == 0, 16'(n));
            n_checks++;
            if (dout_dv !== e_dv || sync_out !== (n == 5) || abort !== 1'b0
                || (e_dv && dout_dr !== 16'(n))) begin
                n_fail++;
                $display("FAIL post_reset n=%0d: got dv=%b sync=%b abort=%b I=%0d want dv=%b sync=%b I=%0d",
                         n, dout_dv, sync_out, abort, dout_dr, e_dv, n == 5, n);
            end
        end
        n_checks++;
        if (hdr_out !== HDR_A) begin
            n_fail++;
            $display("FAIL post_reset_hdr: got %h want %h", hdr_out, HDR_A);
        end
    endtask

    task automatic test_limits();
        int n_out = 0;
        cp_len = 12'd0; num_sym = 4'd0; hdr_in = HDR_B;
        for (int n = 0; n < 3100; n++) begin
            drive(1'b1, n == 0, 16'(n));
            n_checks++;
            if (dout_dv !== (n < 1536) || sync_out !== (n == 0)) begin
                n_fail++;
                $display("FAIL num_sym0 n=%0d: got dv=%b sync=%b want dv=%b sync=%b",
                         n, dout_dv, sync_out, n < 1536, n == 0);
            end
        end
        cp_len = 12'd4095; num_sym = 4'd1;
        for (int n = 0; n < 5633; n++) begin
            logic e_dv;
            e_dv = (n >= 4095) && (n < 5631);
            drive(n < 5631, n == 0, 16'(n));
            if (dout_dv === 1'b1) n_out++;
            n_checks++;
            if (dout_dv !== e_dv || sync_out !== (n == 4095) || (e_dv && dout_dr !== 16'(n))) begin
                n_fail++;
                $display("FAIL cp4095 n=%0d: got dv=%b sync=%b I=%0d want dv=%b sync=%b I=%0d",
                         n, dout_dv, sync_out, dout_dr, e_dv, n == 4095, n);
            end
        end
        n_checks++;
        if (n_out != 1536) begin
            n_fail++;
            $display("FAIL cp4095_count: got %0d outputs want 1536", n_out);
        end
    endtask

    initial begin
        rst_n = 1'b0; din_dr = '0; din_di = '0; din_dv = 1'b0; sync_in = 1'b0;
        hdr_in = '0; cp_len = '0; num_sym = '0;
        #1;
        test_reset();
        test_basic();
        test_multi();
        test_sparse();
        test_restart();
        test_reset_unqual();
        test_limits();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prach_fft_framer.md
# prach_fft_framer

- Sits directly upstream of the PRACH FFT and produces its input stream.
- Consumes the decimated PRACH IQ stream, which carries a start-of-occasion strobe and header.
- Discards the cyclic prefix, then emits a configured number of back-to-back 1536-sample symbols.
- Each symbol is presented as one FFT frame: `sync_out` is asserted on its first valid sample and `hdr_out` is updated on that same cycle.

## Interface
Parameters:
- `HDR_WIDTH`, default 120: width of the header word.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `din_dr` / `din_di` in 16 each: signed input I/Q.
- `din_dv` in 1: input sample valid; may be sparse.
- `sync_in` in 1: start of occasion; only meaningful while `din_dv`=1.
- `hdr_in` in `HDR_WIDTH`: occasion header, sampled on a qualified `sync_in`.
- `cp_len` in 12: cyclic-prefix length in samples, sampled on a qualified `sync_in`.
- `num_sym` in 4: number of symbols in the occasion, sampled on a qualified `sync_in`; 0 is treated as 1.
- `dout_dr` / `dout_di` out 16 each: output I/Q, connected to FFT `din_dr` / `din_di`.
- `dout_dv` out 1: output sample valid.
- `sync_out` out 1: first sample of each symbol.
- `hdr_out` out `HDR_WIDTH`: header of the current occasion.
- `sym_idx` out 4: symbol index within the occasion, valid with `dout_dv`.
- `abort` out 1: one-cycle pulse when an occasion is cut short.

## Operation
- **Qualified start:** `sync_in` & `din_dv`. `sync_in` with `din_dv`=0 is ignored.
- **States:** IDLE, CP, SYM.
  - IDLE: on a qualified start, latch `cp_len`, `num_sym`, `hdr_in`.
    - `cp_len`>0: go to CP. The start sample is CP sample 0.
    - `cp_len`=0: go directly to SYM. The start sample is symbol 0, sample 0.
  - CP: counts valid samples. After `cp_len` valid samples have been dropped, the next valid sample is symbol 0, sample 0 (state SYM).
  - SYM: the sample counter runs 0..1535 on valid samples only.
    - At 1535 with `sym_cnt` < `num_sym`-1: increment `sym_cnt`, sample counter returns to 0.
    - At 1535 with `sym_cnt` = `num_sym`-1: go to IDLE.
- **Forwarding:** only SYM samples are forwarded; CP and IDLE samples are dropped (`dout_dv`=0).
- **Header:** `hdr_out` is loaded on every `sync_out` cycle and held between them, so all symbols of one occasion carry the same header.
- **Restart:** a qualified start while in CP or SYM abandons the current occasion.
  - `abort` pulses.
  - The new occasion is latched and started from that same sample, with the same rules as from IDLE.
  - The partial symbol is not padded; the downstream FFT resynchronises on `sync_out`.
- **Arithmetic:** I/Q pass through bit-exact; no scaling.
- **Counter widths:** CP counter 12 bit, sample counter 11 bit, `sym_cnt` 4 bit. `cp_len`=4095 is legal.

## Timing
- **Latency:** exactly 1 cycle, din→dout, for a forwarded sample. All outputs are registered.
- **Output alignment:** `dout_dv`, `sync_out`, `sym_idx`, `hdr_out` and `abort` are cycle-aligned with the forwarded data.
- **Aborted occasion:** `abort` appears on the output cycle corresponding to the restarting input sample.
- **Reset values:** all outputs 0 (`dout_*`, `dout_dv`, `sync_out`, `hdr_out`, `sym_idx`, `abort`); state IDLE; all counters 0.
- **Reset during an occasion:** the occasion is dropped silently, with no `abort`. `dout_dv` is 0 on the cycle after `rst_n` is sampled low.
- **Gaps:** `din_dv`=0 cycles stall all counters and give `dout_dv`=0 one cycle later.
- **Throughput:** one sample per cycle; no backpressure and no internal buffering.

## Configuration
- `PRACH_FRAMER_ABORT_CNT_EN` defined:
  - adds output `abort_cnt` (16 bit, saturating at 0xFFFF);
  - it increments on every `abort` pulse and resets to 0.
- Not defined: the port and counter are absent; `abort` still exists.

## Structure
- **Shared package `prach_pkg`:**
  - `NumFftPoints` = 1536;
  - sample width 16;
  - `CpLenWidth` = 12;
  - `NumSymWidth` = 4;
  - state enum `framer_state_t` {IDLE, CP, SYM}.
- **Sub-module:** none. The counters and FSM sit in one always_ff block and the output register in a second.

## Test plan
- **Basic occasion:** `cp_len`=3072, `num_sym`=1, continuous dv, 4608 samples with ramp I=n.
  - 1536 outputs with I=3072..4607.
  - One `sync_out`, on I=3072.
  - `hdr_out` equals the header applied.
- **Multiple symbols:** `cp_len`=0, `num_sym`=3.
  - `sync_out` on output samples 0, 1536 and 3072.
  - `sym_idx` is 0, 1, 2 across the three symbols.
  - No output after sample 4607.
- **Sparse input:** `din_dv` toggling 1/0, `cp_len`=10, `num_sym`=1.
  - Output sequence identical to the continuous case.
  - Every output lags its input by exactly 1 cycle.
- **Restart mid-symbol:** `cp_len`=0, `num_sym`=2; a new qualified start with a new header at SYM sample 700.
  - `abort`=1 for one cycle.
  - `sync_out` with the new header on that sample.
  - The full new occasion follows; with the macro, `abort_cnt`=1.
- **Reset and unqualified start:**
  - `sync_in` with `din_dv`=0 produces no output.
  - `rst_n`=0 asserted mid-CP gives all outputs 0 on the next cycle.
  - After reset, the next qualified start frames normally.
- **Limits:** `num_sym`=0 gives one symbol; `cp_len`=4095 gives the first output equal to input sample 4095.
